// File: rtl/cpu_writeback.sv
// cpu_writeback: final pipeline stage; 2-entry in-order result buffer that
// commits to the register file through an arbitrated write port.
// Ports: i_clock, i_reset (async active-low), i_valid/o_ready push handshake,
// i_inst_rd/i_rd result in, o_rf_write/o_rf_index/o_rf_data + i_rf_grant
// register file port, o_wb_inst_rd/o_wb_rd forwarding slot, o_pending mask,
// o_instret retired counter (only when CPU_WB_INSTRET_EN is defined).
module cpu_writeback #(
    parameter int DEPTH = 2
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [4:0]  i_inst_rd,
    input  logic [31:0] i_rd,
    output logic        o_rf_write,
    output logic [4:0]  o_rf_index,
    output logic [31:0] o_rf_data,
    input  logic        i_rf_grant,
    output logic [4:0]  o_wb_inst_rd,
    output logic [31:0] o_wb_rd,
    output logic [31:0] o_pending
`ifdef CPU_WB_INSTRET_EN
    ,
    output logic [63:0] o_instret
`endif
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    logic [4:0]  inst_q [2];
    logic [31:0] data_q [2];
    logic        rptr;
    logic        wptr;
    logic [1:0]  count;

    logic        head_valid;
    logic        head_x0;
    logic [4:0]  head_inst;
    logic [31:0] head_data;
    logic        push;
    logic        retire;
    logic [1:0]  ent_valid;

    assign head_inst  = inst_q[rptr];
    assign head_data  = data_q[rptr];
    assign head_valid = (count != 2'd0);
    assign head_x0    = (head_inst == 5'd0);

    // Full buffer refuses a push even if the head retires this cycle,
    // which keeps o_ready a pure function of registered state.
    assign o_ready = (count != FULL);
    assign push    = i_valid && o_ready;

    // x0 heads drain without touching the register file.
    assign retire = head_valid && (head_x0 || i_rf_grant);

    assign o_rf_write = head_valid && !head_x0;
    assign o_rf_index = o_rf_write ? head_inst : 5'd0;
    assign o_rf_data  = o_rf_write ? head_data : 32'd0;

    assign o_wb_inst_rd = head_valid ? head_inst : 5'd0;
    // An x0 head forwards zero so an rs == x0 match stays architecturally 0.
    assign o_wb_rd = o_rf_write ? head_data : 32'd0;

    always_comb begin
        ent_valid[0] = (count == FULL) || ((count == 2'd1) && !rptr);
        ent_valid[1] = (count == FULL) || ((count == 2'd1) && rptr);
    end

    always_comb begin
        o_pending = 32'd0;
        for (int i = 0; i < 2; i++) begin
            if (ent_valid[i]) begin
                o_pending[inst_q[i]] = 1'b1;
            end
        end
        o_pending[0] = 1'b0;
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < 2; i++) begin
                inst_q[i] <= 5'd0;
                data_q[i] <= 32'd0;
            end
        end else if (push) begin
            inst_q[wptr] <= i_inst_rd;
            data_q[wptr] <= i_rd;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            rptr  <= 1'b0;
            wptr  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) begin
                wptr <= ~wptr;
            end
            if (retire) begin
                rptr <= ~rptr;
            end
            unique case ({push, retire})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef CPU_WB_INSTRET_EN
    logic [63:0] instret_q;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            instret_q <= 64'd0;
        end else if (retire) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign o_instret = instret_q;
`endif

endmodule

// File: tb/tb_cpu_writeback.sv
// tb_cpu_writeback: vector table plus commit scoreboard for cpu_writeback.
// Optional instret checks are compiled with CPU_WB_INSTRET_EN.
module tb_cpu_writeback;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [4:0]  i_inst_rd = 5'd0;
    logic [31:0] i_rd = 32'd0;
    logic        o_rf_write;
    logic [4:0]  o_rf_index;
    logic [31:0] o_rf_data;
    logic        i_rf_grant = 1'b0;
    logic [4:0]  o_wb_inst_rd;
    logic [31:0] o_wb_rd;
    logic [31:0] o_pending;
`ifdef CPU_WB_INSTRET_EN
    logic [63:0] o_instret;
`endif

    cpu_writeback #(.DEPTH(2)) dut (
        .i_clock(i_clock),
        .i_reset(i_reset),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_inst_rd(i_inst_rd),
        .i_rd(i_rd),
        .o_rf_write(o_rf_write),
        .o_rf_index(o_rf_index),
        .o_rf_data(o_rf_data),
        .i_rf_grant(i_rf_grant),
        .o_wb_inst_rd(o_wb_inst_rd),
        .o_wb_rd(o_wb_rd),
`ifdef CPU_WB_INSTRET_EN
        .o_pending(o_pending),
        .o_instret(o_instret)
`else
        .o_pending(o_pending)
`endif
    );

    always #5 i_clock = ~i_clock;

    typedef struct {
        logic        v;
        logic [4:0]  inst;
        logic [31:0] rd;
        logic        g;
        logic        ready;
        logic        write;
        logic [4:0]  idx;
        logic [31:0] data;
        logic [4:0]  wbi;
        logic [31:0] wbd;
        logic [31:0] pend;
    } vec_t;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
    } wr_t;

    vec_t vecs[21];
    wr_t  sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    function automatic vec_t mk(
        input logic v, input logic [4:0] inst, input logic [31:0] rd,
        input logic g, input logic ready, input logic write,
        input logic [4:0] idx, input logic [31:0] data,
        input logic [31:0] pend
    );
        vec_t t;
        t.v = v; t.inst = inst; t.rd = rd; t.g = g;
        t.ready = ready; t.write = write; t.idx = idx; t.data = data;
        t.wbi = idx; t.wbd = data; t.pend = pend;
        return t;
    endfunction

    task automatic chk_idle(input string n);
        chk({n, " ready"}, 64'(o_ready), 64'd1);
        chk({n, " write"}, 64'(o_rf_write), 64'd0);
        chk({n, " idx"}, 64'(o_rf_index), 64'd0);
        chk({n, " data"}, 64'(o_rf_data), 64'd0);
        chk({n, " wbi"}, 64'(o_wb_inst_rd), 64'd0);
        chk({n, " wbd"}, 64'(o_wb_rd), 64'd0);
        chk({n, " pend"}, 64'(o_pending), 64'd0);
`ifdef CPU_WB_INSTRET_EN
        chk({n, " instret"}, o_instret, 64'd0);
`endif
    endtask

    // Commits happen on the edge after this sample when write && grant.
    initial begin
        forever begin
            @(negedge i_clock);
            #2;
            if (i_reset && o_rf_write && i_rf_grant) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL commit: unexpected write x%0d=%0h", o_rf_index, o_rf_data);
                end else begin
                    wr_t w;
                    w = sb.pop_front();
                    chk("commit idx", 64'(o_rf_index), 64'(w.idx));
                    chk("commit data", 64'(o_rf_data), 64'(w.data));
                end
            end
        end
    end

    initial begin
        vecs[0]  = mk(1, 5, 32'h11, 1,   1, 0, 0, 0, 0);
        vecs[1]  = mk(1, 6, 32'h22, 1,   1, 1, 5, 32'h11, 32'h20);
        vecs[2]  = mk(1, 7, 32'h33, 1,   1, 1, 6, 32'h22, 32'h40);
        vecs[3]  = mk(0, 0, 0, 1,        1, 1, 7, 32'h33, 32'h80);
        vecs[4]  = mk(0, 0, 0, 0,        1, 0, 0, 0, 0);
        vecs[5]  = mk(1, 3, 32'hA, 0,    1, 0, 0, 0, 0);
        vecs[6]  = mk(1, 4, 32'hB, 0,    1, 1, 3, 32'hA, 32'h08);
        vecs[7]  = mk(1, 9, 32'h99, 0,   0, 1, 3, 32'hA, 32'h18);
        vecs[8]  = mk(0, 0, 0, 1,        0, 1, 3, 32'hA, 32'h18);
        vecs[9]  = mk(0, 0, 0, 0,        1, 1, 4, 32'hB, 32'h10);
        vecs[10] = mk(0, 0, 0, 1,        1, 1, 4, 32'hB, 32'h10);
        vecs[11] = mk(1, 0, 32'hDEAD, 0, 1, 0, 0, 0, 0);
        vecs[12] = mk(1, 8, 32'h88, 0,   1, 0, 0, 0, 0);
        vecs[13] = mk(0, 0, 0, 1,        1, 1, 8, 32'h88, 32'h100);
        vecs[14] = mk(0, 0, 0, 0,        1, 0, 0, 0, 0);
        vecs[15] = mk(1, 10, 32'h1010, 0, 1, 0, 0, 0, 0);
        vecs[16] = mk(1, 11, 32'h1111, 0, 1, 1, 10, 32'h1010, 32'h400);
        vecs[17] = mk(1, 12, 32'h1212, 1, 0, 1, 10, 32'h1010, 32'hC00);
        vecs[18] = mk(0, 0, 0, 0,        1, 1, 11, 32'h1111, 32'h800);
        vecs[19] = mk(0, 0, 0, 1,        1, 1, 11, 32'h1111, 32'h800);
        vecs[20] = mk(0, 0, 0, 0,        1, 0, 0, 0, 0);

        repeat (2) @(negedge i_clock);
        #1;
        chk_idle("in reset");
        @(negedge i_clock);
        i_reset = 1'b1;
        #1;
        chk_idle("after reset");

        for (int i = 0; i < 21; i++) begin
            @(negedge i_clock);
            i_valid    = vecs[i].v;
            i_inst_rd  = vecs[i].inst;
            i_rd       = vecs[i].rd;
            i_rf_grant = vecs[i].g;
            #1;
            chk($sformatf("v%0d ready", i), 64'(o_ready), 64'(vecs[i].ready));
            chk($sformatf("v%0d write", i), 64'(o_rf_write), 64'(vecs[i].write));
            chk($sformatf("v%0d idx", i), 64'(o_rf_index), 64'(vecs[i].idx));
            chk($sformatf("v%0d data", i), 64'(o_rf_data), 64'(vecs[i].data));
            chk($sformatf("v%0d wbi", i), 64'(o_wb_inst_rd), 64'(vecs[i].wbi));
            chk($sformatf("v%0d wbd", i), 64'(o_wb_rd), 64'(vecs[i].wbd));
            chk($sformatf("v%0d pend", i), 64'(o_pending), 64'(vecs[i].pend));
            if (vecs[i].v && vecs[i].ready && vecs[i].inst != 5'd0) begin
                sb.push_back('{vecs[i].inst, vecs[i].rd});
            end
        end
        @(negedge i_clock);
        i_valid = 1'b0;
        i_rf_grant = 1'b0;
        #1;
        chk("scoreboard drained", 64'(sb.size()), 64'd0);

`ifdef CPU_WB_INSTRET_EN
        chk("instret count", o_instret, 64'd9);
        force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instret_q;
        @(negedge i_clock);
        i_valid = 1'b1;
        i_inst_rd = 5'd0;
        i_rd = 32'h5;
        @(negedge i_clock);
        i_valid = 1'b0;
        #1;
        chk("instret preload", o_instret, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge i_clock);
        #1;
        chk("instret wrap", o_instret, 64'd0);
`endif

        @(negedge i_clock);
        i_valid = 1'b1;
        i_inst_rd = 5'd13;
        i_rd = 32'h1313;
        i_rf_grant = 1'b0;
        @(negedge i_clock);
        i_inst_rd = 5'd14;
        i_rd = 32'h1414;
        @(negedge i_clock);
        i_valid = 1'b0;
        #1;
        chk("pre-reset ready", 64'(o_ready), 64'd0);
        chk("pre-reset pend", 64'(o_pending), 64'h6000);
        #2;
        i_reset = 1'b0;
        #1;
        chk_idle("mid reset");
        @(negedge i_clock);
        i_reset = 1'b1;
        i_rf_grant = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("post reset %0d write", i), 64'(o_rf_write), 64'd0);
            chk($sformatf("post reset %0d pend", i), 64'(o_pending), 64'd0);
            chk($sformatf("post reset %0d ready", i), 64'(o_ready), 64'd1);
            @(negedge i_clock);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
